// File: rtl/memristor_pulse_sequencer_pkg.sv
// Shared state encoding and default sizing for the memristor pulse sequencer.
package memristor_seq_pkg;
  localparam int DEF_N_CH      = 3;
  localparam int DEF_NUM_W     = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_SETUP_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } seq_state_t;
endpackage

// File: rtl/memristor_pulse_sequencer_if.sv
// Request/config inputs and SEL/DIGITALIN outputs of the pulse sequencer.
// MEMR_SEQ_ABORT_EN adds the abort input to both modports.
interface memristor_pulse_sequencer_if
  import memristor_seq_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int NUM_W = DEF_NUM_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic [N_CH-1:0]  req;
  logic [NUM_W-1:0] cfg_num_pulses;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [N_CH-1:0]  grant;
  logic [N_CH-1:0]  sel;
  logic [N_CH-1:0]  din;
  logic             busy;
  logic             done;
  logic [N_CH-1:0]  done_ch;
  logic             aborted;
`ifdef MEMR_SEQ_ABORT_EN
  logic             abort;

  modport master (
    output req, cfg_num_pulses, cfg_width, cfg_gap, abort,
    input  grant, sel, din, busy, done, done_ch, aborted
  );
  modport slave (
    input  req, cfg_num_pulses, cfg_width, cfg_gap, abort,
    output grant, sel, din, busy, done, done_ch, aborted
  );
`else
  modport master (
    output req, cfg_num_pulses, cfg_width, cfg_gap,
    input  grant, sel, din, busy, done, done_ch, aborted
  );
  modport slave (
    input  req, cfg_num_pulses, cfg_width, cfg_gap,
    output grant, sel, din, busy, done, done_ch, aborted
  );
`endif
endinterface

// File: rtl/memristor_pulse_sequencer_rr_arbiter.sv
// Round-robin one-hot picker; grant is combinational, pointer moves to winner+1 on i_adv.
module memristor_rr_arbiter
  import memristor_seq_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
)(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_req,
  input  logic            i_adv,
  output logic [N_CH-1:0] o_gnt
);
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] w_idx;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_idx     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % N_CH);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
        w_ptr_nxt    = (w_idx == PTR_W'(N_CH - 1)) ? '0 : w_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= w_ptr_nxt;
    end
  end
endmodule

// File: rtl/memristor_pulse_sequencer.sv
// Shares one pulse timer among N_CH memristor cells: arbitrates, drives SEL, emits guarded DIGITALIN bursts.
// All outputs registered; MEMR_SEQ_ABORT_EN enables the abort input.
module memristor_pulse_sequencer
  import memristor_seq_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int NUM_W     = DEF_NUM_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC
)(
  input logic wb_clk_i,
  input logic wb_rst_i,
  memristor_pulse_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(SETUP_CYC - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [NUM_W-1:0] r_pcnt;
  logic [NUM_W-1:0] w_pcnt_nxt;
  logic [NUM_W-1:0] w_pcnt_inc;
  logic [NUM_W-1:0] r_num;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] w_width_eff;
  logic [CNT_W-1:0] w_gap_eff;
  logic [N_CH-1:0]  r_win;
  logic [N_CH-1:0]  w_win_nxt;
  logic [N_CH-1:0]  w_arb_gnt;
  logic             r_abt;
  logic             w_abt_nxt;
  logic             w_adv;
  logic             w_abort;
  logic             w_active;

  logic [N_CH-1:0]  r_grant;
  logic [N_CH-1:0]  r_sel;
  logic [N_CH-1:0]  r_din;
  logic [N_CH-1:0]  r_done_ch;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic [N_CH-1:0]  w_sel_nxt;
  logic [N_CH-1:0]  w_din_nxt;
  logic [N_CH-1:0]  w_done_ch_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_aborted_nxt;

`ifdef MEMR_SEQ_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_width_eff = (bus.cfg_width == '0) ? CNT_W'(1) : bus.cfg_width;
  assign w_gap_eff   = (bus.cfg_gap == '0) ? CNT_W'(1) : bus.cfg_gap;

  memristor_rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_req (bus.req),
    .i_adv (w_adv),
    .o_gnt (w_arb_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pcnt_nxt  = r_pcnt;
    w_win_nxt   = r_win;
    w_abt_nxt   = r_abt;
    w_adv       = 1'b0;
    w_pcnt_inc  = r_pcnt + NUM_W'(1);
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_adv       = 1'b1;
          w_win_nxt   = w_arb_gnt;
          w_pcnt_nxt  = '0;
          w_abt_nxt   = 1'b0;
          w_cnt_nxt   = GUARD_LD;
          w_state_nxt = (bus.cfg_num_pulses == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = r_width - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HIGH: begin
        if (r_cnt == '0) begin
          w_pcnt_nxt = w_pcnt_inc;
          if (w_pcnt_inc == r_num) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = GUARD_LD;
          end else begin
            w_state_nxt = LOW;
            w_cnt_nxt   = r_gap - CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (r_cnt == '0) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = r_width - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Abort still routes through HOLD so SEL keeps its release guard time.
    if (w_abort && (r_state inside {SETUP, HIGH, LOW})) begin
      w_state_nxt = HOLD;
      w_cnt_nxt   = GUARD_LD;
      w_abt_nxt   = 1'b1;
    end

    // Outputs are decoded from the next state so they can be registered glitch-free.
    w_active      = (w_state_nxt inside {SETUP, HIGH, LOW, HOLD});
    w_sel_nxt     = w_active ? w_win_nxt : '0;
    w_din_nxt     = (w_state_nxt == HIGH) ? w_win_nxt : '0;
    w_done_nxt    = (w_state_nxt == DONE);
    w_done_ch_nxt = w_done_nxt ? w_win_nxt : '0;
    w_aborted_nxt = w_done_nxt & w_abt_nxt;
    w_busy_nxt    = (w_state_nxt != IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt     <= '0;
      r_pcnt    <= '0;
      r_num     <= '0;
      r_width   <= '0;
      r_gap     <= '0;
      r_win     <= '0;
      r_abt     <= 1'b0;
      r_grant   <= '0;
      r_sel     <= '0;
      r_din     <= '0;
      r_done_ch <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_win     <= w_win_nxt;
      r_abt     <= w_abt_nxt;
      if (w_adv) begin
        r_num   <= bus.cfg_num_pulses;
        r_width <= w_width_eff;
        r_gap   <= w_gap_eff;
      end
      r_grant   <= w_sel_nxt;
      r_sel     <= w_sel_nxt;
      r_din     <= w_din_nxt;
      r_done_ch <= w_done_ch_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  assign bus.grant   = r_grant;
  assign bus.sel     = r_sel;
  assign bus.din     = r_din;
  assign bus.done_ch = r_done_ch;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.aborted = r_aborted;
endmodule

// File: tb/tb_memristor_pulse_sequencer.sv
// Scoreboard bench: each burst's expected waveform is queued at request time and checked cycle by cycle.
module tb_memristor_pulse_sequencer;
  localparam int SC = 2;

  typedef struct {
    int ch;
    int n;
    int w;
    int g;
    int exp_start;
    bit chain;
    int abort_k;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  exp_t sb_q[$];
  exp_t cur;
  bit   act = 1'b0;
  bit   hit;
  int   s, k, last_done, weff, geff, act_end, lend, last_din;
  logic [2:0] oh, e_sel, e_din;
  logic       e_done;

  memristor_pulse_sequencer_if bus_if ();

  memristor_pulse_sequencer dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int ch, input int n, input int w, input int g,
                          input int start, input bit chain, input int abk);
    exp_t e;
    e.ch = ch; e.n = n; e.w = w; e.g = g;
    e.exp_start = start; e.chain = chain; e.abort_k = abk;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] r, input int n, input int w, input int g);
    bus_if.req            = r;
    bus_if.cfg_num_pulses = 4'(n);
    bus_if.cfg_width      = 8'(w);
    bus_if.cfg_gap        = 8'(g);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || act) && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("drain", 32'(sb_q.size() == 0 && !act), 32'd1);
  endtask

  task automatic check_start(input exp_t e);
    if (e.chain) check_eq("rearb_gap", 32'(cyc), 32'(last_done + 2));
    else         check_eq("start_cycle", 32'(cyc), 32'(e.exp_start));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      act = 1'b0;
      sb_q.delete();
    end else begin
      hit = 1'b0;
      check_eq("one_sel", 32'($countones(bus_if.sel) <= 1), 32'd1);
      check_eq("din_in_sel", 32'(bus_if.din & ~bus_if.sel), 32'd0);
      if (!act && sb_q.size() > 0) begin
        cur = sb_q[0];
        oh  = 3'b001 << cur.ch;
        if (cur.n == 0) begin
          if (bus_if.done) begin
            void'(sb_q.pop_front());
            hit = 1'b1;
            check_eq("n0_done_ch", 32'(bus_if.done_ch), 32'(oh));
            check_eq("n0_quiet", 32'({bus_if.sel, bus_if.din, bus_if.grant, bus_if.aborted}), 32'd0);
            check_start(cur);
            last_done = cyc;
          end else begin
            check_eq("wait_quiet", 32'({bus_if.sel, bus_if.din, bus_if.done_ch}), 32'd0);
          end
        end else if (bus_if.grant != 3'b000) begin
          void'(sb_q.pop_front());
          hit = 1'b1;
          act = 1'b1;
          s   = cyc;
          check_start(cur);
        end else begin
          check_eq("wait_quiet", 32'({bus_if.sel, bus_if.din, bus_if.done, bus_if.done_ch}), 32'd0);
        end
      end else if (!act) begin
        check_eq("idle", 32'({bus_if.sel, bus_if.din, bus_if.grant, bus_if.done, bus_if.busy}), 32'd0);
      end

      if (act) begin
        hit      = 1'b1;
        k        = cyc - s;
        weff     = (cur.w == 0) ? 1 : cur.w;
        geff     = (cur.g == 0) ? 1 : cur.g;
        act_end  = SC + cur.n * weff + (cur.n - 1) * geff;
        lend     = (cur.abort_k >= 0) ? cur.abort_k + 1 + SC : act_end + SC;
        last_din = (cur.abort_k >= 0) ? cur.abort_k : 1 << 30;
        e_sel    = (k < lend) ? oh : 3'b000;
        e_din    = (k >= SC && k < act_end && k <= last_din &&
                    ((k - SC) % (weff + geff)) < weff) ? oh : 3'b000;
        e_done   = (k == lend);
        check_eq("sel", 32'(bus_if.sel), 32'(e_sel));
        check_eq("grant", 32'(bus_if.grant), 32'(e_sel));
        check_eq("din", 32'(bus_if.din), 32'(e_din));
        check_eq("busy", 32'(bus_if.busy), 32'd1);
        check_eq("done", 32'(bus_if.done), 32'(e_done));
        check_eq("done_ch", 32'(bus_if.done_ch), 32'(e_done ? oh : 3'b000));
        check_eq("aborted", 32'(bus_if.aborted), 32'(e_done && cur.abort_k >= 0));
        if (e_done) begin
          act       = 1'b0;
          last_done = cyc;
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive(3'b000, 0, 0, 0);
`ifdef MEMR_SEQ_ABORT_EN
    bus_if.abort = 1'b0;
`endif
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("reset_outs", 32'({bus_if.grant, bus_if.sel, bus_if.din, bus_if.done_ch,
                                bus_if.busy, bus_if.done, bus_if.aborted}), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);

    // Three requesters held: rotation 0,1,2,0 with an idle cycle between bursts.
    drive(3'b111, 1, 1, 0);
    push_exp(0, 1, 1, 0, cyc + 1, 1'b0, -1);
    push_exp(1, 1, 1, 0, -1, 1'b1, -1);
    push_exp(2, 1, 1, 0, -1, 1'b1, -1);
    push_exp(0, 1, 1, 0, -1, 1'b1, -1);
    step(23);
    bus_if.req = 3'b000;
    drain(100);

    // Zero pulses: done the cycle after the grant edge, SEL never raised.
    drive(3'b010, 0, 5, 5);
    push_exp(1, 0, 5, 5, cyc + 1, 1'b0, -1);
    step(1);
    bus_if.req = 3'b000;
    drain(50);

    // Zero width and gap behave as one cycle each.
    drive(3'b100, 3, 0, 0);
    push_exp(2, 3, 0, 0, cyc + 1, 1'b0, -1);
    step(1);
    bus_if.req = 3'b000;
    drain(50);

    // Reference burst; req drop and cfg changes after grant must not disturb it.
    drive(3'b001, 2, 3, 2);
    push_exp(0, 2, 3, 2, cyc + 1, 1'b0, -1);
    step(1);
    drive(3'b000, 9, 7, 7);
    drain(50);

    // Async reset during HIGH clears outputs and the round-robin pointer.
    drive(3'b010, 2, 4, 1);
    push_exp(1, 2, 4, 1, cyc + 1, 1'b0, -1);
    step(4);
    check_eq("pre_rst_din", 32'(bus_if.din), 32'(3'b010));
    rst = 1'b1;
    #2;
    check_eq("rst_async", 32'({bus_if.grant, bus_if.sel, bus_if.din, bus_if.busy}), 32'd0);
    bus_if.req = 3'b000;
    step(2);
    rst = 1'b0;
    step(1);
    drive(3'b111, 0, 1, 1);
    push_exp(0, 0, 1, 1, cyc + 1, 1'b0, -1);
    step(1);
    bus_if.req = 3'b000;
    drain(50);

`ifdef MEMR_SEQ_ABORT_EN
    // Abort in the second HIGH of a four-pulse burst.
    drive(3'b001, 4, 2, 2);
    push_exp(0, 4, 2, 2, cyc + 1, 1'b0, 6);
    step(7);
    bus_if.abort = 1'b1;
    step(1);
    bus_if.abort = 1'b0;
    bus_if.req   = 3'b000;
    drain(60);
`endif

    step(3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end
endmodule
